sort_frame_loader: RTL

//  Upstream feeder for the bitonic sorter.
//  - Packs a valid/ready stream of values into SIZE-wide frames.
//  - Pads short frames with PAD_VALUE and launches each frame as a one-cycle pulse on the sorter input.
//  - Carries frame length and valid through a delay line that matches the sorter latency.
//  - Limits frames in flight with credits returned by the downstream consumer.

---
 rtl/sort_frame_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sort_frame_loader.sv
// Frame loader feeding the bitonic sorter: packs a valid/ready stream into padded
// SIZE-wide frames, launches them under credit control and tracks sorter latency.
module sort_frame_loader #(
  parameter int unsigned             VALUE_BITS   = 8,
  parameter int unsigned             DEPTH        = 2,
  parameter int unsigned             SIZE         = 1 << DEPTH,
  parameter logic [VALUE_BITS-1:0]   PAD_VALUE    = '1,
  parameter int unsigned             SORT_LATENCY = 1,
  parameter int unsigned             MAX_INFLIGHT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [VALUE_BITS-1:0]        s_data,
  input  logic                         s_last,
  output logic [SIZE*VALUE_BITS-1:0]   sort_in,
  output logic                         sort_in_valid,
  output logic                         sorted_valid,
  output logic [DEPTH:0]               sorted_len,
  input  logic                         frame_done,
  output logic                         credit_err
);

  localparam int unsigned LW = DEPTH + 1;
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned FW = SIZE * VALUE_BITS;

  typedef enum logic {FILL, HOLD} state_t;

  state_t            state;
  logic [DEPTH-1:0]  idx;
  logic [FW-1:0]     asm_q;
  logic [FW-1:0]     frame_c;
  logic [LW-1:0]     hold_len;
  logic [LW-1:0]     launch_len;
  logic [LW-1:0]     len_c;
  logic [IW-1:0]     inflight;
  logic [LW:0]       dly [SORT_LATENCY];

  logic hs_c;
  logic complete_c;
  logic credit_c;
  logic launch_c;
  logic dec_c;

  // Readiness is a pure function of state, gated off while reset is asserted.
  assign s_ready    = (state == FILL) && !rst;
  assign hs_c       = s_valid && s_ready;
  assign complete_c = hs_c && ((idx == DEPTH'(SIZE - 1)) || s_last);
  assign credit_c   = (inflight < IW'(MAX_INFLIGHT)) || frame_done;
  assign launch_c   = credit_c && (((state == FILL) && complete_c) || (state == HOLD));
  assign dec_c      = frame_done && (inflight != '0);
  assign len_c      = LW'(idx) + LW'(1);

  // Assembly frame as it looks after this beat: earlier slots kept, later slots padded.
  always_comb begin
    frame_c = asm_q;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (DEPTH'(i) == idx)
        frame_c[i*VALUE_BITS +: VALUE_BITS] = s_data;
      else if (DEPTH'(i) > idx)
        frame_c[i*VALUE_BITS +: VALUE_BITS] = PAD_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FILL;
      idx           <= '0;
      asm_q         <= '0;
      hold_len      <= '0;
      launch_len    <= '0;
      inflight      <= '0;
      credit_err    <= 1'b0;
      sort_in       <= '0;
      sort_in_valid <= 1'b0;
      for (int k = 0; k < SORT_LATENCY; k++) dly[k] <= '0;
    end else begin
      sort_in_valid <= 1'b0;

      if (launch_c) begin
        sort_in_valid <= 1'b1;
        sort_in       <= (state == HOLD) ? asm_q : frame_c;
        launch_len    <= (state == HOLD) ? hold_len : len_c;
      end

      case (state)
        FILL: begin
          if (hs_c) begin
            asm_q <= frame_c;
            if (complete_c) begin
              idx      <= '0;
              hold_len <= len_c;
              if (!credit_c) state <= HOLD;
            end else begin
              idx <= idx + DEPTH'(1);
            end
          end
        end
        HOLD: begin
          if (credit_c) state <= FILL;
        end
        default: state <= FILL;
      endcase

      // Launch and credit return in the same cycle cancel out.
      if (launch_c && !dec_c)
        inflight <= inflight + IW'(1);
      else if (!launch_c && dec_c)
        inflight <= inflight - IW'(1);

      if (frame_done && (inflight == '0)) credit_err <= 1'b1;

      dly[0] <= {sort_in_valid, sort_in_valid ? launch_len : LW'(0)};
      for (int k = 1; k < SORT_LATENCY; k++) dly[k] <= dly[k-1];
    end
  end

  assign sorted_valid = dly[SORT_LATENCY-1][LW];
  assign sorted_len   = dly[SORT_LATENCY-1][LW-1:0];

endmodule
